// File: rtl/sipo_frame_ctrl_if.sv
// Serial source / parallel consumer bundle of the SIPO frame controller.
// master = stimulus/consumer side, slave = the controller itself.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             bit_vld_i;
  logic             x_i;
  logic             word_rdy_i;
  logic             clr_ovf_i;
  logic [WIDTH-1:0] word_o;
  logic             word_vld_o;
  logic             busy_o;
  logic             ovf_o;

  modport master (
    output start_i, bit_vld_i, x_i, word_rdy_i, clr_ovf_i,
    input  word_o, word_vld_o, busy_o, ovf_o
  );

  modport slave (
    input  start_i, bit_vld_i, x_i, word_rdy_i, clr_ovf_i,
    output word_o, word_vld_o, busy_o, ovf_o
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frames a qualified LSB-first serial stream into WIDTH-bit words; word_vld_o rises on the edge
// sampling the last bit. One-word holding register: a completion while the held word is stalled is dropped and sets sticky ovf_o.
module sipo_frame_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  sipo_frame_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] word_q;
  logic             word_vld_q;
  logic             ovf_q;

  logic             frame_init;
  logic             shift_en;
  logic             done;
  logic             drop;
  logic [WIDTH-1:0] cand;

  assign cand = {bus.x_i, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = SHIFT;
      SHIFT:   if (!bus.start_i && bus.bit_vld_i && cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Restart beats a data bit arriving in the same cycle.
  always_comb begin
    frame_init = bus.start_i;
    shift_en   = (state_q == SHIFT) && !bus.start_i && bus.bit_vld_i;
    done       = shift_en && (cnt_q == LAST);
    drop       = done && word_vld_q && !bus.word_rdy_i;
    bus.busy_o = (state_q == SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (frame_init) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= cand;
      cnt_q <= done ? '0 : cnt_q + 1'b1;
    end
  end

  // A completion coinciding with a transfer reloads without dropping valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else if (done && !drop) begin
      word_q     <= cand;
      word_vld_q <= 1'b1;
    end else if (word_vld_q && bus.word_rdy_i) begin
      word_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             ovf_q <= 1'b0;
    else if (drop)          ovf_q <= 1'b1;
    else if (bus.clr_ovf_i) ovf_q <= 1'b0;
  end

  assign bus.word_o     = word_q;
  assign bus.word_vld_o = word_vld_q;
  assign bus.ovf_o      = ovf_q;

endmodule
